// File: rtl/alu_arbiter_if.sv
// ============================================================================
// Module   : alu_arbiter_if
// Brief    : Request/response bundle between two client engines and alu_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_arbiter_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int COUNT_WIDTH   = 16
);
  logic                     req0_valid;
  logic                     req0_ready;
  logic [DATA_WIDTH-1:0]    req0_a;
  logic [DATA_WIDTH-1:0]    req0_b;
  logic [ADDRESS_WIDTH-1:0] req0_opcode;

  logic                     req1_valid;
  logic                     req1_ready;
  logic [DATA_WIDTH-1:0]    req1_a;
  logic [DATA_WIDTH-1:0]    req1_b;
  logic [ADDRESS_WIDTH-1:0] req1_opcode;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic                     rsp_id;
  logic [DATA_WIDTH-1:0]    rsp_data;
  logic                     rsp_carry;

  logic                     busy;
  logic [COUNT_WIDTH-1:0]   op_count;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_opcode,
    input  req1_valid, req1_a, req1_b, req1_opcode,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_carry,
    output busy, op_count
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_opcode,
    output req1_valid, req1_a, req1_b, req1_opcode,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_carry,
    input  busy, op_count
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter (with helper alu_arbiter_alu)
// Brief    : Round-robin sharing of one combinational ALU between two requesters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_arbiter_alu #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
) (
  input  wire logic [DATA_WIDTH-1:0]    a,
  input  wire logic [DATA_WIDTH-1:0]    b,
  input  wire logic [ADDRESS_WIDTH-1:0] opcode,
  output logic      [DATA_WIDTH:0]      result
);
  localparam logic [ADDRESS_WIDTH-1:0] c_OP_A    = ADDRESS_WIDTH'(0);
  localparam logic [ADDRESS_WIDTH-1:0] c_OP_ADD  = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH-1:0] c_OP_ADDC = ADDRESS_WIDTH'(2);
  localparam logic [ADDRESS_WIDTH-1:0] c_OP_SUB  = ADDRESS_WIDTH'(3);
  localparam logic [ADDRESS_WIDTH-1:0] c_OP_SUBB = ADDRESS_WIDTH'(4);
  localparam logic [ADDRESS_WIDTH-1:0] c_OP_INC  = ADDRESS_WIDTH'(5);
  localparam logic [ADDRESS_WIDTH-1:0] c_OP_DEC  = ADDRESS_WIDTH'(6);
  localparam logic [ADDRESS_WIDTH-1:0] c_OP_B    = ADDRESS_WIDTH'(7);
  localparam logic [ADDRESS_WIDTH-1:0] c_OP_OR   = ADDRESS_WIDTH'(8);
  localparam logic [ADDRESS_WIDTH-1:0] c_OP_XOR  = ADDRESS_WIDTH'(9);
  localparam logic [ADDRESS_WIDTH-1:0] c_OP_AND  = ADDRESS_WIDTH'(10);
  localparam logic [ADDRESS_WIDTH-1:0] c_OP_NOT  = ADDRESS_WIDTH'(11);

  // Operands are zero-extended so the top bit of a subtraction is the borrow.
  logic [DATA_WIDTH:0] w_a;
  logic [DATA_WIDTH:0] w_b;
  logic [DATA_WIDTH:0] w_one;

  assign w_a   = {1'b0, a};
  assign w_b   = {1'b0, b};
  assign w_one = (DATA_WIDTH+1)'(1);

  always_comb begin
    result = '0;
    case (opcode)
      c_OP_A:    result = w_a;
      c_OP_ADD:  result = w_a + w_b;
      c_OP_ADDC: result = w_a + w_b + w_one;
      c_OP_SUB:  result = w_a - w_b;
      c_OP_SUBB: result = w_a - w_b - w_one;
      c_OP_INC:  result = w_a + w_one;
      c_OP_DEC:  result = w_a - w_one;
      c_OP_B:    result = w_b;
      c_OP_OR:   result = w_a | w_b;
      c_OP_XOR:  result = w_a ^ w_b;
      c_OP_AND:  result = w_a & w_b;
      c_OP_NOT:  result = {1'b0, ~a};
      default:   result = '0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int COUNT_WIDTH   = 16
) (
  input wire logic     clk,
  input wire logic     rst,
  alu_arbiter_if.slave bus
);
  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_EXEC = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;

  logic [1:0]               r_state;
  logic [1:0]               w_next_state;

  logic                     r_prio;
  logic [DATA_WIDTH-1:0]    r_a;
  logic [DATA_WIDTH-1:0]    r_b;
  logic [ADDRESS_WIDTH-1:0] r_opcode;
  logic                     r_id;

  logic [DATA_WIDTH-1:0]    r_rsp_data;
  logic                     r_rsp_carry;
  logic                     r_rsp_id;
  logic [COUNT_WIDTH-1:0]   r_op_count;

  logic                     w_grant_id;
  logic                     w_accept;
  logic                     w_rsp_done;
  logic                     w_ready0;
  logic                     w_ready1;
  logic                     w_busy;
  logic                     w_rsp_valid;

  logic [DATA_WIDTH-1:0]    w_sel_a;
  logic [DATA_WIDTH-1:0]    w_sel_b;
  logic [ADDRESS_WIDTH-1:0] w_sel_opcode;
  logic [DATA_WIDTH:0]      w_alu_result;

  // Arbitration: a lone requester wins outright, a tie goes to the pointer.
  always_comb begin
    w_grant_id = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      w_grant_id = r_prio;
    end else if (bus.req1_valid) begin
      w_grant_id = 1'b1;
    end
  end

  assign w_accept     = (r_state == c_IDLE) && (bus.req0_valid || bus.req1_valid);
  assign w_rsp_done   = w_rsp_valid && bus.rsp_ready;

  assign w_sel_a      = w_grant_id ? bus.req1_a      : bus.req0_a;
  assign w_sel_b      = w_grant_id ? bus.req1_b      : bus.req0_b;
  assign w_sel_opcode = w_grant_id ? bus.req1_opcode : bus.req0_opcode;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (w_accept) w_next_state = c_EXEC;
      c_EXEC:  w_next_state = c_RESP;
      c_RESP:  if (bus.rsp_ready) w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // Output logic; readies depend only on state, valids and the pointer.
  always_comb begin
    w_ready0    = 1'b0;
    w_ready1    = 1'b0;
    w_busy      = 1'b1;
    w_rsp_valid = 1'b0;
    case (r_state)
      c_IDLE: begin
        w_busy   = 1'b0;
        w_ready0 = bus.req0_valid && !w_grant_id;
        w_ready1 = bus.req1_valid &&  w_grant_id;
      end
      c_RESP:  w_rsp_valid = 1'b1;
      default: w_rsp_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_opcode <= '0;
      r_id     <= 1'b0;
    end else if (w_accept) begin
      r_prio   <= ~w_grant_id;
      r_a      <= w_sel_a;
      r_b      <= w_sel_b;
      r_opcode <= w_sel_opcode;
      r_id     <= w_grant_id;
    end
  end

  alu_arbiter_alu #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_alu (
    .a      (r_a),
    .b      (r_b),
    .opcode (r_opcode),
    .result (w_alu_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_id    <= 1'b0;
    end else if (r_state == c_EXEC) begin
      r_rsp_data  <= w_alu_result[DATA_WIDTH-1:0];
      r_rsp_carry <= w_alu_result[DATA_WIDTH];
      r_rsp_id    <= r_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_rsp_done && (r_op_count != {COUNT_WIDTH{1'b1}})) begin
      r_op_count <= r_op_count + COUNT_WIDTH'(1);
    end
  end

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_carry  = r_rsp_carry;
  assign bus.busy       = w_busy;
  assign bus.op_count   = r_op_count;
endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Directed self-checking bench for alu_arbiter (2-bit op counter).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp     = 0;
  int   n_fail    = 0;
  int   exp_count = 0;

  alu_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW)) bus ();

  alu_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bump();
    if (exp_count < 3) exp_count++;
  endtask

  task automatic idle_inputs();
    bus.req0_valid  = 1'b0;
    bus.req0_a      = '0;
    bus.req0_b      = '0;
    bus.req0_opcode = '0;
    bus.req1_valid  = 1'b0;
    bus.req1_a      = '0;
    bus.req1_b      = '0;
    bus.req1_opcode = '0;
    bus.rsp_ready   = 1'b1;
  endtask

  task automatic drive(input bit id, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] op);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_opcode = op;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_opcode = op;
    end
  endtask

  // Full transaction with rsp_ready high; operands are scrambled after the
  // handshake so a late-sampling design would produce the wrong result.
  task automatic run_op(input string tag, input bit id, input logic [7:0] a,
                        input logic [7:0] b, input logic [3:0] op,
                        input logic [7:0] ed, input logic ec);
    int k;
    drive(id, a, b, op);
    bus.rsp_ready = 1'b1;
    #1;
    k = 0;
    while (((id ? bus.req1_ready : bus.req0_ready) !== 1'b1) && k < 20) begin
      tick(); #1; k++;
    end
    check({tag, "_ready"}, 32'(id ? bus.req1_ready : bus.req0_ready), 32'd1);
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = ~a; bus.req1_a = ~a; bus.req0_b = ~b; bus.req1_b = ~b;
    check({tag, "_exec_busy"},  32'(bus.busy),      32'd1);
    check({tag, "_exec_valid"}, 32'(bus.rsp_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_id"},    32'(bus.rsp_id),    32'(id));
    check({tag, "_data"},  32'(bus.rsp_data),  32'(ed));
    check({tag, "_carry"}, 32'(bus.rsp_carry), 32'(ec));
    tick();
    bump();
    check({tag, "_count"}, 32'(bus.op_count), 32'(exp_count));
    check({tag, "_idle"},  32'(bus.busy),     32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy",   32'(bus.busy),       32'd0);
    check("rst_valid",  32'(bus.rsp_valid),  32'd0);
    check("rst_id",     32'(bus.rsp_id),     32'd0);
    check("rst_data",   32'(bus.rsp_data),   32'd0);
    check("rst_carry",  32'(bus.rsp_carry),  32'd0);
    check("rst_count",  32'(bus.op_count),   32'd0);
    check("rst_ready0", 32'(bus.req0_ready), 32'd0);
    check("rst_ready1", 32'(bus.req1_ready), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_ready0", 32'(bus.req0_ready), 32'd0);

    // F0 + 20 = 0x110
    run_op("add", 1'b0, 8'hF0, 8'h20, 4'd1, 8'h10, 1'b1);

    rst = 1'b1;
    #1;
    exp_count = 0;
    check("rst2_count", 32'(bus.op_count), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Both valid continuously: grants alternate 0,1,0,1 from prio = 0.
    drive(1'b0, 8'h05, 8'h07, 4'd3);
    drive(1'b1, 8'h00, 8'h00, 4'd6);
    #1;
    for (int i = 0; i < 4; i++) begin
      logic eid;
      eid = i[0];
      check("rr_ready0", 32'(bus.req0_ready), 32'(!eid));
      check("rr_ready1", 32'(bus.req1_ready), 32'(eid));
      tick();
      tick();
      check("rr_id",    32'(bus.rsp_id),    32'(eid));
      check("rr_data",  32'(bus.rsp_data),  eid ? 32'hFF : 32'hFE);
      check("rr_carry", 32'(bus.rsp_carry), 32'd1);
      tick();
      bump();
      check("rr_count", 32'(bus.op_count), 32'(exp_count));
      #1;
    end
    idle_inputs();
    tick();

    run_op("inc_wrap", 1'b1, 8'hFF, 8'h00, 4'd5,  8'h00, 1'b1);
    run_op("sub_brw",  1'b0, 8'h10, 8'h01, 4'd4,  8'h0E, 1'b0);
    run_op("op15",     1'b1, 8'h33, 8'h44, 4'd15, 8'h00, 1'b0);
    run_op("not_a",    1'b0, 8'hA5, 8'h00, 4'd11, 8'h5A, 1'b0);
    run_op("xor",      1'b1, 8'hF0, 8'h3C, 4'd9,  8'hCC, 1'b0);
    run_op("addc",     1'b0, 8'hFF, 8'h00, 4'd2,  8'h00, 1'b1);
    run_op("pass_b",   1'b1, 8'h12, 8'h34, 4'd7,  8'h34, 1'b0);
    run_op("and",      1'b0, 8'hC3, 8'h5A, 4'd10, 8'h42, 1'b0);

    // Backpressure: response held while req1 keeps requesting.
    bus.rsp_ready = 1'b0;
    drive(1'b1, 8'h0F, 8'hF0, 4'd8);
    #1;
    check("bp_accept", 32'(bus.req1_ready), 32'd1);
    tick();
    bus.req1_a = 8'h00;
    check("bp_exec_ready1", 32'(bus.req1_ready), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",  32'(bus.rsp_valid),  32'd1);
      check("bp_data",   32'(bus.rsp_data),   32'hFF);
      check("bp_id",     32'(bus.rsp_id),     32'd1);
      check("bp_ready0", 32'(bus.req0_ready), 32'd0);
      check("bp_ready1", 32'(bus.req1_ready), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bump();
    check("bp_idle",   32'(bus.busy),       32'd0);
    check("bp_count",  32'(bus.op_count),   32'(exp_count));
    check("bp_regrnt", 32'(bus.req1_ready), 32'd1);
    tick();
    check("bp_exec2", 32'(bus.busy), 32'd1);
    bus.req1_valid = 1'b0;
    tick();
    check("bp_data2", 32'(bus.rsp_data), 32'hF0);
    tick();
    bump();

    // Reset during EXEC of a req0 op (which leaves prio pointing at req1).
    check("pre_rst_count", 32'(bus.op_count), 32'd3);
    drive(1'b0, 8'h77, 8'h11, 4'd1);
    #1;
    check("mid_ready0", 32'(bus.req0_ready), 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    exp_count = 0;
    check("arst_busy",  32'(bus.busy),      32'd0);
    check("arst_valid", 32'(bus.rsp_valid), 32'd0);
    check("arst_data",  32'(bus.rsp_data),  32'd0);
    check("arst_id",    32'(bus.rsp_id),    32'd0);
    check("arst_carry", 32'(bus.rsp_carry), 32'd0);
    check("arst_count", 32'(bus.op_count),  32'd0);
    tick();
    check("arst_norsp", 32'(bus.rsp_valid), 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 8'h01, 8'h02, 4'd1);
    drive(1'b1, 8'h05, 8'h06, 4'd1);
    #1;
    check("post_ready0", 32'(bus.req0_ready), 32'd1);
    check("post_ready1", 32'(bus.req1_ready), 32'd0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    check("post_valid", 32'(bus.rsp_valid), 32'd1);
    check("post_id",    32'(bus.rsp_id),    32'd0);
    check("post_data",  32'(bus.rsp_data),  32'h03);
    tick();
    bump();
    check("post_count", 32'(bus.op_count), 32'(exp_count));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational `ALU` instance between two requesters. Each requester has its own valid/ready request port. Operands are registered into the ALU and the result is registered out on a single response port tagged with the requester ID. Round-robin priority is used, with one operation in flight at a time. The block sits between two client engines and the shared ALU datapath.

## Interface
- `DATA_WIDTH`, 8, operand/result width.
- `ADDRESS_WIDTH`, 4, opcode width (passed to `ALU`).
- `COUNT_WIDTH`, 16, width of completed-operation counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when valid&ready.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  DATA_WIDTH  operands.
- `req0_opcode` / `req1_opcode`  in  ADDRESS_WIDTH  ALU opcode.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_id`  out  1  requester that issued the response (0/1).
- `rsp_data`  out  DATA_WIDTH  ALU result.
- `rsp_carry`  out  1  ALU carry/borrow bit.
- `busy`  out  1  state != IDLE.
- `op_count`  out  COUNT_WIDTH  completed responses; saturates at all-ones.

## Operation
- States:
  - IDLE: waiting for a request.
  - EXEC: operands are registered and the ALU is evaluating.
  - RESP: the result is held until the consumer accepts it.
- IDLE:
  - `reqN_ready` = 1 only for the granted requester; otherwise 0.
  - Grant when exactly one requester is valid: that requester.
  - Grant when both are valid: the requester selected by priority pointer `prio`.
  - Grant when neither is valid: no ready is asserted.
  - On handshake: capture a, b, opcode and id into the operand registers, go to EXEC, and set `prio` = ~granted id.
- EXEC:
  - Register ALU outputs into `rsp_data`/`rsp_carry`.
  - Set `rsp_id` to the captured id.
  - Go to RESP.
- RESP:
  - `rsp_valid` = 1; all rsp_* outputs are held stable.
  - On `rsp_valid & rsp_ready`: go to IDLE and increment `op_count`, saturating.
  - The response handshake cycle never also accepts a request; both readies are 0 outside IDLE.
- ALU semantics:
  - The result is computed at DATA_WIDTH+1 bits.
  - `rsp_carry` = bit DATA_WIDTH and `rsp_data` = the low DATA_WIDTH bits.
- Opcodes:
  - 0: A.
  - 1: A+B.
  - 2: A+B+1.
  - 3: A−B.
  - 4: A−B−1.
  - 5: A+1.
  - 6: A−1.
  - 7: B.
  - 8: OR.
  - 9: XOR.
  - 10: AND.
  - 11: ~A.
  - 12–15: result 0, carry 0.
- Request inputs are sampled only on the handshake edge. Changes to them afterwards do not affect the in-flight operation.
- A requester that drops valid before being granted is simply not served. No request state is kept.

## Timing
- Reset values:
  - State is IDLE.
  - `prio` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0, `rsp_carry` = 0.
  - `busy` = 0, `op_count` = 0, and operand registers = 0.
  - Both readies are 0 until the first cycle out of reset in which a request is valid.
- Request handshake in cycle N: EXEC in N+1, `rsp_valid` high from N+2.
- Minimum spacing between accepts is 3 cycles, with `rsp_ready` held high.
- With `rsp_ready` low, RESP holds indefinitely and no new request is accepted.
- Readies are combinational from `reqN_valid`, `prio` and state. There is no combinational path from `rsp_ready` to `reqN_ready`.
- Reset asserted mid-operation (EXEC or RESP):
  - All registers clear immediately.
  - The in-flight transaction is discarded with no response.
  - `op_count` clears.

## Test plan
- Req0 opcode 1, a=8'hF0, b=8'h20, with `rsp_ready`=1 → two cycles after handshake: `rsp_valid`=1, `rsp_id`=0, `rsp_data`=8'h10, `rsp_carry`=1; `op_count`=1.
- Both requesters valid continuously, ops 3 (5−7) on req0 and 6 (0−1) on req1, starting from reset → grants in order id 0, 1, 0, 1.
  - req0 responses: 8'hFE, carry 1.
  - req1 responses: 8'hFF, carry 1.
- Edge opcodes: opcode 5 with a=8'hFF → 8'h00, carry 1. Opcode 4 with a=8'h10, b=8'h01 → 8'h0E, carry 0. Opcode 15 → 8'h00, carry 0. Opcode 11 with a=8'hA5 → 8'h5A, carry 0.
- Backpressure: hold `rsp_ready`=0 for 5 cycles while req1 stays valid → rsp_* stable and both readies 0 throughout. Raise `rsp_ready` → IDLE the next cycle, then req1 is accepted.
- Reset during EXEC with `op_count`=3 → all outputs return to reset values asynchronously and no response appears. After release, a new request completes normally with `rsp_id` following `prio`=0.
- Saturation with COUNT_WIDTH=2: complete 5 operations → `op_count` reads 3 after the third and stays at 3.
